// File: rtl/alu_ctrl_mdu.sv
// ALU control decoder with an iterative RV32M multiply/divide unit.
// Latency: 1 cycle for ALU/load/store/branch decode, XLEN+1 cycles for M ops.
// Backpressure: the result is held stable until res_ready; dec_ready stays low while an M op runs.
module alu_ctrl_mdu #(
    parameter int XLEN   = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            dec_valid,
    output logic            dec_ready,
    input  logic [1:0]      alu_op,
    input  logic [2:0]      funct3,
    input  logic            funct7_5,
    input  logic            funct7_0,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    output logic            ctrl_valid,
    input  logic            res_ready,
    output logic [3:0]      out_to_alu,
    output logic [1:0]      equal_comp,
    output logic [2:0]      mem,
    output logic            ctrl_illegal,
    output logic            md_sel,
    output logic [XLEN-1:0] md_result,
    output logic            busy
);
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_XOR  = 4'b0110;
    localparam logic [3:0] OP_SLTU = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;
    localparam int         CW      = 7;
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_MD_RUN, S_MD_DONE} state_t;

    state_t            state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic [1:0]        eq_q, eq_d;
    logic [2:0]        mem_q, mem_d;
    logic              ill_q, ill_d, sel_q, sel_d;
    logic [XLEN-1:0]   res_q, res_d;
    logic [2:0]        f3_q, f3_d;
    logic              neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d;
    logic [XLEN-1:0]   a_q, a_d, mc_q, mc_d, hi_q, hi_d, lo_q, lo_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic [3:0]        dc_op;
    logic [1:0]        dc_eq;
    logic [2:0]        dc_mem;
    logic              dc_ill, dc_is_m;
    logic              sgn1, sgn2, neg1, neg2;
    logic [XLEN-1:0]   mag1, mag2;
    logic [XLEN:0]     mul_sum, div_sh;
    logic              div_ge;
    logic [XLEN-1:0]   step_hi, step_lo, quo, rem, md_fin;
    logic [2*XLEN-1:0] prod, prod_c;
    logic              rdy_int, accept;

    // Instruction-class decode into ALU op, branch sense and access size.
    always_comb begin
        dc_op   = OP_AND;
        dc_eq   = 2'b00;
        dc_mem  = 3'b000;
        dc_ill  = 1'b0;
        dc_is_m = 1'b0;
        case (alu_op)
            2'b00: begin
                if (funct7_0) begin
                    if (MUL_EN) dc_is_m = 1'b1;
                    else        dc_ill  = 1'b1;
                end else begin
                    case ({funct7_5, funct3})
                        4'b0000: dc_op = OP_ADD;
                        4'b1000: dc_op = OP_SUB;
                        4'b0001: dc_op = OP_SLL;
                        4'b0010: dc_op = OP_SLT;
                        4'b0011: dc_op = OP_SLTU;
                        4'b0100: dc_op = OP_XOR;
                        4'b0101: dc_op = OP_SRL;
                        4'b1101: dc_op = OP_SRA;
                        4'b0110: dc_op = OP_OR;
                        4'b0111: dc_op = OP_AND;
                        default: dc_ill = 1'b1;
                    endcase
                end
            end
            2'b01: begin
                case (funct3)
                    3'b000:  dc_op = OP_ADD;
                    3'b001:  dc_op = OP_SLL;
                    3'b010:  dc_op = OP_SLT;
                    3'b011:  dc_op = OP_SLTU;
                    3'b100:  dc_op = OP_XOR;
                    3'b101:  dc_op = funct7_5 ? OP_SRA : OP_SRL;
                    3'b110:  dc_op = OP_OR;
                    default: dc_op = OP_AND;
                endcase
            end
            2'b10: begin
                dc_op = OP_ADD;
                case (funct3)
                    3'b000:  dc_mem = 3'b001;
                    3'b001:  dc_mem = 3'b010;
                    3'b010:  dc_mem = 3'b011;
                    3'b100:  dc_mem = 3'b100;
                    3'b101:  dc_mem = 3'b101;
                    default: dc_ill = 1'b1;
                endcase
            end
            default: begin
                dc_eq = funct3[0] ? 2'b10 : 2'b11;
                case (funct3[2:1])
                    2'b00:   dc_op  = OP_SUB;
                    2'b10:   dc_op  = OP_SLT;
                    2'b11:   dc_op  = OP_SLTU;
                    default: dc_ill = 1'b1;
                endcase
            end
        endcase
        if (dc_ill) begin
            dc_op  = 4'b0000;
            dc_eq  = 2'b00;
            dc_mem = 3'b000;
        end
    end

    // Operand signedness per M op and conversion to magnitudes.
    always_comb begin
        sgn1 = (funct3 != 3'b011) && (funct3 != 3'b101) && (funct3 != 3'b111);
        sgn2 = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        neg1 = sgn1 && rs1_val[XLEN-1];
        neg2 = sgn2 && rs2_val[XLEN-1];
        mag1 = neg1 ? -rs1_val : rs1_val;
        mag2 = neg2 ? -rs2_val : rs2_val;
    end

    // One shift-add or restoring-divide step, plus sign correction of the final step.
    always_comb begin
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mc_q} : '0);
        div_sh  = {hi_q, lo_q[XLEN-1]};
        div_ge  = (div_sh >= {1'b0, mc_q});
        if (f3_q[2]) begin
            step_hi = div_ge ? XLEN'(div_sh - {1'b0, mc_q}) : div_sh[XLEN-1:0];
            step_lo = {lo_q[XLEN-2:0], div_ge};
        end else begin
            step_hi = mul_sum[XLEN:1];
            step_lo = {mul_sum[0], lo_q[XLEN-1:1]};
        end
        prod   = {step_hi, step_lo};
        prod_c = neg_q ? -prod : prod;
        quo    = neg_q ? -step_lo : step_lo;
        rem    = rneg_q ? -step_hi : step_hi;
        case (f3_q)
            3'b000:                 md_fin = prod_c[XLEN-1:0];
            3'b001, 3'b010, 3'b011: md_fin = prod_c[2*XLEN-1:XLEN];
            3'b100, 3'b101:         md_fin = dz_q ? '1 : quo;
            default:                md_fin = dz_q ? a_q : rem;
        endcase
    end

    // Next-state: accept/retire handshakes and iteration of the M datapath.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        eq_d    = eq_q;
        mem_d   = mem_q;
        ill_d   = ill_q;
        sel_d   = sel_q;
        res_d   = res_q;
        f3_d    = f3_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        a_d     = a_q;
        mc_d    = mc_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        rdy_int = (state_q == S_IDLE) ||
                  (((state_q == S_HOLD) || (state_q == S_MD_DONE)) && res_ready);
        accept  = dec_valid && rdy_int;
        if (state_q == S_MD_RUN) begin
            hi_d  = step_hi;
            lo_d  = step_lo;
            cnt_d = cnt_q + 7'd1;
            if (cnt_q == LAST) begin
                state_d = S_MD_DONE;
                op_d    = OP_ADD;
                sel_d   = 1'b1;
                res_d   = md_fin;
            end
        end else if (accept) begin
            op_d  = dc_op;
            eq_d  = dc_eq;
            mem_d = dc_mem;
            ill_d = dc_ill;
            sel_d = 1'b0;
            res_d = '0;
            if (dc_is_m) begin
                state_d = S_MD_RUN;
                f3_d    = funct3;
                neg_d   = neg1 ^ neg2;
                rneg_d  = neg1;
                dz_d    = (rs2_val == '0);
                a_d     = rs1_val;
                mc_d    = mag2;
                hi_d    = '0;
                lo_d    = mag1;
                cnt_d   = '0;
            end else begin
                state_d = S_HOLD;
            end
        end else if (state_q != S_IDLE && res_ready) begin
            state_d = S_IDLE;
        end
    end

    // State and result registers; reset discards any op in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            eq_q    <= '0;
            mem_q   <= '0;
            ill_q   <= 1'b0;
            sel_q   <= 1'b0;
            res_q   <= '0;
            f3_q    <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            a_q     <= '0;
            mc_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            eq_q    <= eq_d;
            mem_q   <= mem_d;
            ill_q   <= ill_d;
            sel_q   <= sel_d;
            res_q   <= res_d;
            f3_q    <= f3_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            a_q     <= a_d;
            mc_q    <= mc_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs read as zero for the whole time reset is held.
    assign dec_ready    = !rst && rdy_int;
    assign ctrl_valid   = !rst && ((state_q == S_HOLD) || (state_q == S_MD_DONE));
    assign busy         = !rst && (state_q == S_MD_RUN);
    assign out_to_alu   = rst ? 4'b0000 : op_q;
    assign equal_comp   = rst ? 2'b00 : eq_q;
    assign mem          = rst ? 3'b000 : mem_q;
    assign ctrl_illegal = !rst && ill_q;
    assign md_sel       = !rst && sel_q;
    assign md_result    = rst ? '0 : res_q;
endmodule

// File: tb/tb_alu_ctrl_mdu.sv
module tb_alu_ctrl_mdu;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, dec_valid, dec_valid0, res_ready, funct7_5, funct7_0;
    logic [1:0]  alu_op;
    logic [2:0]  funct3;
    logic [31:0] rs1_val, rs2_val;

    logic        dec_ready, ctrl_valid, ctrl_illegal, md_sel, busy;
    logic [3:0]  out_to_alu;
    logic [1:0]  equal_comp;
    logic [2:0]  mem;
    logic [31:0] md_result;

    logic        dec_ready0, ctrl_valid0, ctrl_illegal0, md_sel0, busy0;
    logic [3:0]  out_to_alu0;
    logic [1:0]  equal_comp0;
    logic [2:0]  mem0;
    logic [7:0]  md_result0;

    alu_ctrl_mdu #(.XLEN(32), .MUL_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_ready(dec_ready),
        .alu_op(alu_op), .funct3(funct3), .funct7_5(funct7_5), .funct7_0(funct7_0),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .ctrl_valid(ctrl_valid), .res_ready(res_ready),
        .out_to_alu(out_to_alu), .equal_comp(equal_comp), .mem(mem),
        .ctrl_illegal(ctrl_illegal), .md_sel(md_sel), .md_result(md_result), .busy(busy)
    );

    alu_ctrl_mdu #(.XLEN(8), .MUL_EN(1'b0)) dut0 (
        .clk(clk), .rst(rst), .dec_valid(dec_valid0), .dec_ready(dec_ready0),
        .alu_op(alu_op), .funct3(funct3), .funct7_5(funct7_5), .funct7_0(funct7_0),
        .rs1_val(rs1_val[7:0]), .rs2_val(rs2_val[7:0]), .ctrl_valid(ctrl_valid0), .res_ready(res_ready),
        .out_to_alu(out_to_alu0), .equal_comp(equal_comp0), .mem(mem0),
        .ctrl_illegal(ctrl_illegal0), .md_sel(md_sel0), .md_result(md_result0), .busy(busy0)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct packed {
        logic       ill;
        logic       is_m;
        logic [3:0] op;
        logic [1:0] eq;
        logic [2:0] mem;
    } exp_t;

    function automatic logic [3:0] alu_code(input string n);
        case (n)
            "AND":   return 4'd0;
            "OR":    return 4'd1;
            "ADD":   return 4'd2;
            "SUB":   return 4'd3;
            "SLL":   return 4'd4;
            "SLT":   return 4'd5;
            "XOR":   return 4'd6;
            "SLTU":  return 4'd7;
            "SRL":   return 4'd8;
            "SRA":   return 4'd9;
            default: return 4'hF;
        endcase
    endfunction

    // Reference decode: instruction -> mnemonic -> code, with "" meaning illegal.
    function automatic exp_t ref_decode(input logic [1:0] cls, input logic [2:0] f3,
                                        input logic f75, input logic f70, input logic mul_en);
        exp_t  e;
        string nm;
        string rtab [16];
        string btab [8];
        int    mtab [8];
        rtab = '{"ADD", "SLL", "SLT", "SLTU", "XOR", "SRL", "OR", "AND",
                 "SUB", "", "", "", "", "SRA", "", ""};
        btab = '{"SUB", "SUB", "", "", "SLT", "SLT", "SLTU", "SLTU"};
        mtab = '{1, 2, 3, 0, 4, 5, 0, 0};
        e  = '0;
        nm = "";
        case (cls)
            2'd0: begin
                if (f70) e.is_m = mul_en;
                else     nm = rtab[{f75, f3}];
            end
            2'd1: begin
                nm = rtab[{1'b0, f3}];
                if (f3 == 3'd5 && f75) nm = "SRA";
            end
            2'd2: begin
                if (mtab[f3] != 0) begin
                    nm    = "ADD";
                    e.mem = 3'(mtab[f3]);
                end
            end
            default: begin
                nm = btab[f3];
                e.eq = f3[0] ? 2'b10 : 2'b11;
            end
        endcase
        if (!e.is_m) begin
            if (nm == "") begin
                e     = '0;
                e.ill = 1'b1;
            end else begin
                e.op = alu_code(nm);
            end
        end
        return e;
    endfunction

    // Reference M results from plain 64-bit arithmetic.
    function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        logic            ovf;
        sa  = $signed(a);
        sb  = $signed(b);
        ua  = {32'h0, a};
        ub  = {32'h0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf)    return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf)    return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [13:0] all_out();
        return {dec_ready, ctrl_valid, busy, ctrl_illegal, md_sel, out_to_alu, equal_comp, mem};
    endfunction

    function automatic logic [10:0] res_out();
        return {ctrl_illegal, md_sel, out_to_alu, equal_comp, mem};
    endfunction

    function automatic logic [31:0] pick_opnd();
        case ($urandom % 6)
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom % 16);
            default: return $urandom;
        endcase
    endfunction

    // One transaction: accept, measure latency, hold for `stall` cycles, retire.
    // Entered and left just after a rising edge.
    task automatic run_txn(input logic [1:0] cls, input logic [2:0] f3, input logic f75, input logic f70,
                           input logic [31:0] a, input logic [31:0] b, input int stall, input string tag);
        exp_t        e;
        logic [31:0] er;
        logic [10:0] ev;
        int          lat;
        bit          seen;
        e  = ref_decode(cls, f3, f75, f70, 1'b1);
        er = e.is_m ? ref_md(f3, a, b) : 32'h0;
        ev = {e.ill, e.is_m, (e.is_m ? 4'd2 : e.op), e.eq, e.mem};
        alu_op = cls; funct3 = f3; funct7_5 = f75; funct7_0 = f70;
        rs1_val = a; rs2_val = b; dec_valid = 1'b1; res_ready = 1'b0;
        @(negedge clk);
        check({tag, "_rdy"}, dec_ready, 1);
        @(posedge clk);
        #1;
        dec_valid = e.is_m ? 1'($urandom % 2) : 1'b0;
        rs1_val = $urandom; rs2_val = $urandom; funct3 = 3'($urandom); alu_op = 2'($urandom);
        lat  = 0;
        seen = 0;
        for (int c = 1; c <= 100 && !seen; c++) begin
            @(negedge clk);
            if (c == 1) check({tag, "_busy"}, busy, e.is_m);
            if (ctrl_valid) begin
                seen = 1;
                lat  = c;
            end else begin
                @(posedge clk);
            end
        end
        check({tag, "_lat"}, lat, e.is_m ? 33 : 1);
        if (seen) begin
            for (int s = 0; s <= stall; s++) begin
                if (s > 0) begin
                    @(posedge clk);
                    @(negedge clk);
                end
                check({tag, "_res"}, res_out(), ev);
                check({tag, "_md"}, md_result, er);
                check({tag, "_hs"}, {ctrl_valid, dec_ready, busy}, 3'b100);
            end
            dec_valid = 1'b0;
            res_ready = 1'b1;
            @(posedge clk);
            #1 res_ready = 1'b0;
            @(negedge clk);
            check({tag, "_drain"}, {ctrl_valid, dec_ready}, 2'b01);
        end
        @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic [1:0] cls;
        logic [2:0] f3;
    } b2b_t;

    initial begin
        b2b_t        seq [4];
        logic [10:0] ev;
        exp_t        e;
        bit          stray;
        rst = 1'b1; dec_valid = 1'b0; dec_valid0 = 1'b0; res_ready = 1'b0;
        alu_op = 2'd0; funct3 = 3'd0; funct7_5 = 1'b0; funct7_0 = 1'b0;
        rs1_val = 32'h0; rs2_val = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_out", all_out(), 14'h0);
        check("reset_md", md_result, 0);
        check("reset_out0", {dec_ready0, ctrl_valid0, busy0, ctrl_illegal0}, 4'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("release_rdy", all_out(), 14'h2000);
        @(posedge clk);
        #1;

        // Directed decode and M corner cases.
        run_txn(2'd0, 3'b000, 1'b1, 1'b0, 32'h0, 32'h0, 0, "r_sub");
        run_txn(2'd0, 3'b001, 1'b1, 1'b0, 32'h0, 32'h0, 1, "r_ill");
        run_txn(2'd1, 3'b101, 1'b1, 1'b0, 32'h0, 32'h0, 0, "i_srai");
        run_txn(2'd0, 3'b100, 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
        run_txn(2'd0, 3'b110, 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 2, "rem_ovf");
        run_txn(2'd0, 3'b101, 1'b0, 1'b1, 32'd7, 32'd0, 0, "divu_z");
        run_txn(2'd0, 3'b111, 1'b0, 1'b1, 32'd7, 32'd0, 0, "remu_z");
        run_txn(2'd0, 3'b100, 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd0, 0, "div_z");
        run_txn(2'd0, 3'b001, 1'b0, 1'b1, 32'hFFFF_FFFE, 32'd3, 0, "mulh");
        run_txn(2'd0, 3'b000, 1'b0, 1'b1, 32'hFFFF_FFFE, 32'd3, 1, "mul");

        // Back-to-back: BGEU then three loads at one request per cycle.
        seq = '{'{2'd3, 3'b111}, '{2'd2, 3'b000}, '{2'd2, 3'b001}, '{2'd2, 3'b100}};
        res_ready = 1'b1; funct7_5 = 1'b0; funct7_0 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            alu_op = seq[k].cls; funct3 = seq[k].f3; dec_valid = 1'b1;
            @(negedge clk);
            check("b2b_rdy", dec_ready, 1);
            if (k > 0) begin
                e  = ref_decode(seq[k-1].cls, seq[k-1].f3, 1'b0, 1'b0, 1'b1);
                ev = {e.ill, e.is_m, e.op, e.eq, e.mem};
                check("b2b_res", {ctrl_valid, res_out()}, {1'b1, ev});
            end
            @(posedge clk);
            #1;
        end
        dec_valid = 1'b0;
        @(negedge clk);
        e  = ref_decode(seq[3].cls, seq[3].f3, 1'b0, 1'b0, 1'b1);
        ev = {e.ill, e.is_m, e.op, e.eq, e.mem};
        check("b2b_last", {ctrl_valid, res_out()}, {1'b1, ev});
        @(posedge clk);
        #1 res_ready = 1'b0;

        // Reset in the middle of a multiply discards it.
        alu_op = 2'd0; funct3 = 3'd0; funct7_0 = 1'b1; rs1_val = 32'd5; rs2_val = 32'd7;
        dec_valid = 1'b1;
        @(posedge clk);
        #1 dec_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        check("mid_busy", {busy, ctrl_valid}, 2'b10);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("mid_rst_out", all_out(), 14'h0);
        check("mid_rst_md", md_result, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mid_release", all_out(), 14'h2000);
        stray = 1'b0;
        repeat (40) begin
            @(negedge clk);
            stray = stray | ctrl_valid | busy;
        end
        check("mid_no_stray", stray, 0);
        @(posedge clk);
        #1;
        run_txn(2'd0, 3'b000, 1'b0, 1'b0, 32'd1, 32'd2, 0, "after_rst_add");

        // MUL_EN=0 instance treats M encodings as illegal, never busy.
        alu_op = 2'd0; funct3 = 3'd0; funct7_5 = 1'b0; funct7_0 = 1'b1;
        dec_valid0 = 1'b1; res_ready = 1'b1;
        @(negedge clk);
        check("nomul_rdy", dec_ready0, 1);
        @(posedge clk);
        #1 dec_valid0 = 1'b0;
        @(negedge clk);
        e = ref_decode(2'd0, 3'd0, 1'b0, 1'b1, 1'b0);
        check("nomul_res", {ctrl_valid0, ctrl_illegal0, busy0, md_sel0, out_to_alu0, equal_comp0, mem0, md_result0},
              {1'b1, e.ill, 1'b0, 1'b0, e.op, e.eq, e.mem, 8'h0});
        @(posedge clk);
        #1 res_ready = 1'b0;
        @(posedge clk);
        #1;

        // Randomized traffic against the reference model.
        for (int i = 0; i < 250; i++) begin
            logic [1:0] cls;
            logic [2:0] f3;
            logic       f75, f70;
            cls = 2'($urandom % 4);
            f3  = 3'($urandom % 8);
            f75 = 1'($urandom % 2);
            f70 = 1'($urandom % 2);
            run_txn(cls, f3, f75, f70, pick_opnd(), pick_opnd(), int'($urandom % 3), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
